// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the register-file write path: datapath widths, the
// register-zero constant and the buffered MDU result record.
// -----------------------------------------------------------------------------
package cpu_defs;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // Writes to r0 are architecturally discarded and never forwarded.
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // One buffered MDU result. valid=0 marks a slot that still occupies the
    // FIFO but must not reach the regfile (dest r0 or squashed).
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } rf_entry_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// Small circular buffer of MDU results waiting for a free regfile write slot.
// Also performs the per-entry WAW squash and the youngest-match search used by
// the decode-stage bypass.
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   push          store push_entry at the write pointer (caller ensures !full)
//   push_entry    entry to store
//   pop           retire the head entry (caller ensures !empty)
//   squash        a pipeline write to squash_dest happens this cycle
//   squash_dest   destination of that pipeline write
//   head          oldest entry
//   count         number of occupied slots (squashed ones included)
//   fwd_raddr     bypass lookup register
//   fwd_hit       some valid entry targets fwd_raddr
//   fwd_data      data of the youngest such entry
// -----------------------------------------------------------------------------
module wb_result_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  rf_entry_t         push_entry,
    input  logic              pop,
    input  logic              squash,
    input  logic [REG_W-1:0]  squash_dest,
    output rf_entry_t         head,
    output logic [CNT_W-1:0]  count,
    input  logic [REG_W-1:0]  fwd_raddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    logic [DEPTH-1:0]  valid_q;
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Valid bits. A slot's valid bit is cleared when it pops, so valid=1 always
    // implies the slot is occupied; squash and forwarding rely on that.
    // NOTE: sequential state uses non-blocking assignments only; every read in
    // this block sees the pre-edge value, and a later assignment to the same
    // bit overrides an earlier one (push wins over squash of a recycled slot).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && (dest_q[i] == squash_dest)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
            end
            if (push) begin
                // A same-cycle pipeline write to the same register is younger.
                valid_q[wr_ptr] <= push_entry.valid &&
                                   !(squash && (push_entry.dest == squash_dest));
            end
        end
    end

    // Payload storage.
    // NOTE: dest/data are deliberately left out of reset; they are only ever
    // observed through a valid bit or a nonzero count, both of which reset.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= push_entry.dest;
            data_q[wr_ptr] <= push_entry.data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head.valid = valid_q[rd_ptr];
    assign head.dest  = dest_q[rd_ptr];
    assign head.data  = data_q[rd_ptr];

    // Walk from oldest to youngest so the last match found is the youngest.
    // NOTE: every variable written here gets a default first, otherwise the
    // paths that skip an assignment would infer latches.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (valid_q[idx] && (dest_q[idx] == fwd_raddr) && (fwd_raddr != REG_ZERO)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single regfile write port between the in-order writeback stage
// and the multi-cycle MDU. The pipeline always has priority; MDU results wait
// in wb_result_fifo and drain in free cycles. If the FIFO head is blocked for
// STARVE_MAX consecutive cycles, the pipeline is frozen for one cycle so the
// head can drain.
//
// Ports:
//   clk, resetn                          clock, asynchronous active-low reset
//   wb_wen, wb_regsrc, wb_regwdata       writeback-stage write request
//   mdu_valid, mdu_dest, mdu_data        MDU result offer
//   mdu_ready                            buffer can accept an MDU result
//   stall_req                            registered one-cycle pipeline freeze
//   rf_wen, rf_waddr, rf_wdata           regfile write port
//   fwd_raddr, fwd_hit, fwd_data         bypass lookup into buffered results
//   pend_cnt                             buffered entry count
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import cpu_defs::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wb_wen,
    input  logic [4:0]               wb_regsrc,
    input  logic [31:0]              wb_regwdata,
    input  logic                     mdu_valid,
    input  logic [4:0]               mdu_dest,
    input  logic [31:0]              mdu_data,
    output logic                     mdu_ready,
    output logic                     stall_req,
    output logic                     rf_wen,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    input  logic [4:0]               fwd_raddr,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = 4;

    logic             wb_live;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    rf_entry_t        push_entry;
    rf_entry_t        head;
    logic [CNT_W-1:0] count;
    logic [STARVE_W-1:0] starve_cnt;

    // During a stall cycle the held writeback instruction is ignored; it will
    // be presented again and written next cycle.
    assign wb_live    = wb_wen && (wb_regsrc != REG_ZERO) && !stall_req;
    assign fifo_empty = (count == '0);

    // Ready looks only at the registered count: a same-cycle pop does not
    // free a slot for a same-cycle push.
    assign mdu_ready = (count < CNT_W'(DEPTH));
    assign push      = mdu_valid && mdu_ready;
    assign pop       = !wb_live && !fifo_empty;

    assign push_entry.valid = (mdu_dest != REG_ZERO);
    assign push_entry.dest  = mdu_dest;
    assign push_entry.data  = mdu_data;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash      (wb_live),
        .squash_dest (wb_regsrc),
        .head        (head),
        .count       (count),
        .fwd_raddr   (fwd_raddr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    // Grant mux: pipeline first, then the FIFO head (a squashed or r0 head
    // still pops, just without a write).
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_live) begin
            rf_wen   = 1'b1;
            rf_waddr = wb_regsrc;
            rf_wdata = wb_regwdata;
        end else if (!fifo_empty) begin
            rf_wen   = head.valid;
            rf_waddr = head.dest;
            rf_wdata = head.data;
        end
    end

    // Starvation guard. Outside the clear conditions the FIFO is non-empty
    // and not popping, which can only mean the pipeline took the port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else if (starve_cnt == STARVE_W'(STARVE_MAX - 1)) begin
            starve_cnt <= '0;
            stall_req  <= 1'b1;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
            stall_req  <= 1'b0;
        end
    end

    assign pend_cnt = count;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and drained in cycles when the pipeline writeback does not use the port. A starvation guard stalls the pipeline for one cycle when needed. A forwarding port exposes pending buffered results to the decode-stage bypass logic. Sits between writeback_stage outputs and the regfile write port.

Parameters:
DEPTH, 2, number of MDU result buffer entries; power of two, >=2
STARVE_MAX, 4, consecutive blocked-drain cycles before a forced stall; range 1..15

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
wb_wen  in  1  writeback-stage write enable
wb_regsrc  in  5  writeback destination register
wb_regwdata  in  32  writeback data
mdu_valid  in  1  MDU result valid
mdu_dest  in  5  MDU destination register
mdu_data  in  32  MDU result data
mdu_ready  out  1  buffer can accept an MDU result
stall_req  out  1  registered request to freeze the whole pipeline for this cycle
rf_wen  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
fwd_raddr  in  5  bypass lookup address
fwd_hit  out  1  a valid buffered entry targets fwd_raddr
fwd_data  out  32  data of the youngest matching buffered entry
pend_cnt  out  log2(DEPTH)+1  buffered entry count

Behaviour:
- Reset (async, resetn=0): FIFO empty, all entry valid bits 0, rd/wr pointers 0, starvation counter 0, stall_req=0. Resulting outputs: mdu_ready=1, rf_wen=0, fwd_hit=0, pend_cnt=0.
- Pipeline write is live when wb_wen=1, wb_regsrc!=0 and stall_req=0.
- Port grant is combinational with priority to the pipeline write.
  - Pipeline write live: rf_* = wb_*.
  - Else, FIFO non-empty: pop the head; rf_wen=head.valid, rf_waddr/rf_wdata=head fields.
  - Else: rf_wen=0.
- MDU accept occurs when mdu_valid and mdu_ready at the clock edge. The entry is stored with valid=(mdu_dest!=0).
- mdu_ready=(count<DEPTH). It is computed from the registered count only; a same-cycle pop does not raise ready. A full FIFO gives ready=0.
- An accepted entry becomes drainable the cycle after acceptance. There is no same-cycle MDU-to-regfile path.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Squash (WAW ordering; pipeline writes are always younger than MDU results): a live pipeline write to X clears valid on every buffered entry with dest X. It also clears valid on an entry accepted in the same cycle with dest X.
  - A squashed entry still occupies its slot.
  - When it reaches the head it pops in a free cycle with rf_wen=0.
- Starvation counter:
  - Increments in each cycle where the FIFO is non-empty and a live pipeline write takes the port.
  - Clears on any pop or when the FIFO is empty.
  - When it reaches STARVE_MAX, stall_req is registered to 1 for exactly one cycle and the counter clears.
- During a stall_req cycle:
  - The pipeline holds; the held wb_* are ignored (not written, no squash). The same instruction writes on the next cycle.
  - The FIFO head drains.
  - MDU accepts continue normally.
- Forwarding: fwd_hit=1 if any valid entry has dest==fwd_raddr and fwd_raddr!=0. fwd_data comes from the youngest such entry (closest to wr pointer). Output is combinational from registered state. Entries accepted this cycle are not visible until the next cycle.
- pend_cnt=count, including squashed entries.
- Reset asserted mid-operation: buffered results are discarded with no regfile writes.

Decomposition:
- Shared package cpu_defs:
  - REG_W=5, DATA_W=32.
  - Register-zero constant.
  - Entry record {valid, dest, data}.
- One natural sub-module: wb_result_fifo. It holds the storage, pointers and count, the per-entry squash compare and the youngest-match forwarding search. wb_port_arbiter keeps the grant mux, the starvation counter and stall_req.

Test Plan:
- Idle port: mdu_valid with dest=5, data=0x1234 in cycle 0, wb_wen=0 -> cycle 1: rf_wen=1, rf_waddr=5, rf_wdata=0x1234; pend_cnt 1->0.
- Full/back-pressure, DEPTH=2: two MDU results (dest 3, 4) while wb writes continuously -> mdu_ready=0 from cycle 2. Third result held until a pop, then accepted; all three reach the regfile in order 3, 4, third.
- Starvation, STARVE_MAX=4: one buffered entry, wb_wen=1 every cycle -> stall_req=1 on the 5th cycle. In that cycle rf_waddr=head dest. The next cycle writes the held wb instruction.
- Squash: buffered dest=7 data=0xAAAA, then pipeline writes r7=0xBBBB -> fwd_raddr=7 gives fwd_hit=0. The later drain cycle has rf_wen=0. Final r7=0xBBBB.
- Forwarding: entries dest 9 data 0x1 (older) and dest 9 data 0x2 (younger) -> fwd_raddr=9 gives fwd_hit=1, fwd_data=0x2. fwd_raddr=0 gives fwd_hit=0. An MDU result with dest=0 never asserts rf_wen.
- Async reset with 2 entries pending -> immediately pend_cnt=0, mdu_ready=1, stall_req=0. No rf_wen after release until new traffic.
